acc_req_arbiter: RTL

- Multiplexes NumReq accelerator request/response channels (requesters) onto one accelerator channel (accelerator).
- Sits between several cores/offload adapters and a single shared accelerator, or in front of an accelerator address demux.
- Requests use round-robin arbitration with a per-requester outstanding-response limit.
- The requester index is prepended to the request ID; responses are routed back by that index.

---
 rtl/acc_req_arbiter.sv | 265 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/acc_req_arbiter.sv
// acc_req_arbiter
// Round-robin arbiter that multiplexes NumReq accelerator request channels onto
// one accelerator port. Each requester has an outstanding-response limit. The
// grant index is prepended to the request ID, and responses are routed back
// using that index.
// Optional feature macro: ACC_REQ_ARBITER_RSP_CUT_EN. When it is defined, the
// routed response goes through a 2-entry spill register: one cycle of latency,
// full throughput, and mst_p_ready_o comes from register state only.
module acc_req_arbiter #(
   parameter int NumReq         = 4,
   parameter int DataWidth      = 32,
   parameter int AddrWidth      = 3,
   parameter int IdWidth        = 4,
   parameter int MaxOutstanding = 4,
   parameter int IdxW           = (NumReq > 1) ? $clog2(NumReq) : 1,
   parameter int OutIdW         = IdWidth + IdxW
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   // requester-side request channels
   input  logic [NumReq*AddrWidth-1:0]    slv_q_addr_i,
   input  logic [NumReq*32-1:0]           slv_q_data_op_i,
   input  logic [NumReq*DataWidth-1:0]    slv_q_data_arga_i,
   input  logic [NumReq*DataWidth-1:0]    slv_q_data_argb_i,
   input  logic [NumReq*DataWidth-1:0]    slv_q_data_argc_i,
   input  logic [NumReq*IdWidth-1:0]      slv_q_id_i,
   input  logic [NumReq-1:0]              slv_q_wb_i,
   input  logic [NumReq-1:0]              slv_q_valid_i,
   output logic [NumReq-1:0]              slv_q_ready_o,
   // requester-side response channels
   output logic [NumReq*DataWidth-1:0]    slv_p_data0_o,
   output logic [NumReq*DataWidth-1:0]    slv_p_data1_o,
   output logic [NumReq-1:0]              slv_p_dual_writeback_o,
   output logic [NumReq*IdWidth-1:0]      slv_p_id_o,
   output logic [NumReq*5-1:0]            slv_p_rd_o,
   output logic [NumReq-1:0]              slv_p_error_o,
   output logic [NumReq-1:0]              slv_p_valid_o,
   input  logic [NumReq-1:0]              slv_p_ready_i,
   // accelerator-side request channel
   output logic [AddrWidth-1:0]           mst_q_addr_o,
   output logic [31:0]                    mst_q_data_op_o,
   output logic [DataWidth-1:0]           mst_q_data_arga_o,
   output logic [DataWidth-1:0]           mst_q_data_argb_o,
   output logic [DataWidth-1:0]           mst_q_data_argc_o,
   output logic [OutIdW-1:0]              mst_q_id_o,
   output logic                           mst_q_valid_o,
   input  logic                           mst_q_ready_i,
   // accelerator-side response channel
   input  logic [DataWidth-1:0]           mst_p_data0_i,
   input  logic [DataWidth-1:0]           mst_p_data1_i,
   input  logic                           mst_p_dual_writeback_i,
   input  logic [OutIdW-1:0]              mst_p_id_i,
   input  logic [4:0]                     mst_p_rd_i,
   input  logic                           mst_p_error_i,
   input  logic                           mst_p_valid_i,
   output logic                           mst_p_ready_o,
   output logic                           rsp_unexpected_o
);

   localparam int CntW  = $clog2(MaxOutstanding + 1);
   localparam int IdxW1 = IdxW + 1;
   localparam logic [CntW-1:0] CntMax = CntW'(MaxOutstanding);

   typedef struct packed {
      logic [DataWidth-1:0] data0;
      logic [DataWidth-1:0] data1;
      logic                 dual;
      logic [IdWidth-1:0]   id;
      logic [4:0]           rd;
      logic                 error;
      logic [IdxW-1:0]      idx;
   } rsp_t;

   // per-requester views of the flat request buses
   logic [AddrWidth-1:0] q_addr [NumReq];
   logic [31:0]          q_op   [NumReq];
   logic [DataWidth-1:0] q_arga [NumReq];
   logic [DataWidth-1:0] q_argb [NumReq];
   logic [DataWidth-1:0] q_argc [NumReq];
   logic [IdWidth-1:0]   q_id   [NumReq];

   // arbitration state
   logic [IdxW-1:0]  ptr_q, ptr_d;
   logic             lock_q, lock_d;
   logic [IdxW-1:0]  lock_idx_q, lock_idx_d;
   logic [CntW-1:0]  cnt_q [NumReq];
   logic [CntW-1:0]  cnt_d [NumReq];

   logic [NumReq-1:0] eligible;
   logic [NumReq-1:0] cnt_inc, cnt_dec, cnt_zero;
   logic [IdxW-1:0]   grant_idx;
   logic              grant_valid;
   logic [IdxW1-1:0]  cand;
   logic              q_hs;

   // response path
   rsp_t              in_rsp, out_rsp;
   logic [NumReq-1:0] in_oh, out_oh;
   logic              in_bad;
   logic              out_valid, out_ready;
   logic              acc_hs;

   for (genvar gi = 0; gi < NumReq; gi++) begin : g_req
      assign q_addr[gi] = slv_q_addr_i[gi*AddrWidth +: AddrWidth];
      assign q_op[gi]   = slv_q_data_op_i[gi*32 +: 32];
      assign q_arga[gi] = slv_q_data_arga_i[gi*DataWidth +: DataWidth];
      assign q_argb[gi] = slv_q_data_argb_i[gi*DataWidth +: DataWidth];
      assign q_argc[gi] = slv_q_data_argc_i[gi*DataWidth +: DataWidth];
      assign q_id[gi]   = slv_q_id_i[gi*IdWidth +: IdWidth];

      // A write-back request is held off once its requester has the maximum
      // number of responses pending.
      assign eligible[gi] = slv_q_valid_i[gi] && !(slv_q_wb_i[gi] && (cnt_q[gi] == CntMax));

      assign slv_q_ready_o[gi] = !rst_i && grant_valid && (grant_idx == IdxW'(gi)) && mst_q_ready_i;

      // Outstanding counter: increment and decrement in the same cycle cancel,
      // and the decrement saturates at zero (unexpected responses).
      assign cnt_zero[gi] = (cnt_q[gi] == '0);
      assign cnt_inc[gi]  = q_hs && (grant_idx == IdxW'(gi)) && slv_q_wb_i[gi];
      assign cnt_dec[gi]  = acc_hs && in_oh[gi];
      assign cnt_d[gi]    = (cnt_inc[gi] && !cnt_dec[gi]) ? cnt_q[gi] + CntW'(1) :
                            (cnt_dec[gi] && !cnt_inc[gi] && !cnt_zero[gi]) ? cnt_q[gi] - CntW'(1) :
                            cnt_q[gi];

      // response decode: one-hot on the index field, at the accelerator side and at the output
      assign in_oh[gi]  = (in_rsp.idx == IdxW'(gi));
      assign out_oh[gi] = (out_rsp.idx == IdxW'(gi));

      assign slv_p_valid_o[gi]                          = !rst_i && out_valid && out_oh[gi];
      assign slv_p_data0_o[gi*DataWidth +: DataWidth]   = out_rsp.data0;
      assign slv_p_data1_o[gi*DataWidth +: DataWidth]   = out_rsp.data1;
      assign slv_p_dual_writeback_o[gi]                 = out_rsp.dual;
      assign slv_p_id_o[gi*IdWidth +: IdWidth]          = out_rsp.id;
      assign slv_p_rd_o[gi*5 +: 5]                      = out_rsp.rd;
      assign slv_p_error_o[gi]                          = out_rsp.error;
   end

   // Round-robin search from the pointer; a locked grant overrides the search.
   always_comb begin
      grant_idx   = lock_idx_q;
      grant_valid = 1'b0;
      cand        = '0;
      if (lock_q) begin
         grant_valid = eligible[lock_idx_q];
      end else begin
         for (int k = 0; k < NumReq; k++) begin
            cand = {1'b0, ptr_q} + IdxW1'(k);
            if (cand >= IdxW1'(NumReq)) begin
               cand = cand - IdxW1'(NumReq);
            end
            if (!grant_valid && eligible[cand[IdxW-1:0]]) begin
               grant_valid = 1'b1;
               grant_idx   = cand[IdxW-1:0];
            end
         end
      end
   end

   assign mst_q_valid_o     = !rst_i && grant_valid;
   assign mst_q_addr_o      = q_addr[grant_idx];
   assign mst_q_data_op_o   = q_op[grant_idx];
   assign mst_q_data_arga_o = q_arga[grant_idx];
   assign mst_q_data_argb_o = q_argb[grant_idx];
   assign mst_q_data_argc_o = q_argc[grant_idx];
   assign mst_q_id_o        = {grant_idx, q_id[grant_idx]};
   assign q_hs              = mst_q_valid_o && mst_q_ready_i;

   // Next-state for the pointer and the lock that keeps a stalled request stable.
   always_comb begin
      ptr_d      = ptr_q;
      lock_d     = mst_q_valid_o && !mst_q_ready_i;
      lock_idx_d = grant_idx;
      if (q_hs) begin
         if (grant_idx == IdxW'(NumReq - 1)) begin
            ptr_d = '0;
         end else begin
            ptr_d = grant_idx + IdxW'(1);
         end
      end
   end

   // Arbitration and outstanding-counter state registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ptr_q      <= '0;
         lock_q     <= 1'b0;
         lock_idx_q <= '0;
         for (int i = 0; i < NumReq; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         ptr_q      <= ptr_d;
         lock_q     <= lock_d;
         lock_idx_q <= lock_idx_d;
         for (int i = 0; i < NumReq; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign in_rsp = '{data0: mst_p_data0_i,
                     data1: mst_p_data1_i,
                     dual:  mst_p_dual_writeback_i,
                     id:    mst_p_id_i[IdWidth-1:0],
                     rd:    mst_p_rd_i,
                     error: mst_p_error_i,
                     idx:   mst_p_id_i[OutIdW-1 -: IdxW]};

   // An index that matches no requester (possible when NumReq is not a power of two)
   assign in_bad    = ~|in_oh;
   assign out_ready = |(slv_p_ready_i & out_oh);
   assign acc_hs    = mst_p_valid_i && mst_p_ready_o;

   // Pulse when a response is consumed that nobody was waiting for.
   assign rsp_unexpected_o = acc_hs && (in_bad || |(in_oh & cnt_zero));

`ifdef ACC_REQ_ARBITER_RSP_CUT_EN
   rsp_t       sp_mem_q [2];
   logic       sp_wr_q, sp_wr_d;
   logic       sp_rd_q, sp_rd_d;
   logic [1:0] sp_cnt_q, sp_cnt_d;
   logic       sp_push, sp_pop;

   // Misrouted responses are dropped at the input and never occupy an entry.
   assign mst_p_ready_o = !rst_i && (sp_cnt_q != 2'd2);
   assign sp_push       = acc_hs && !in_bad;
   assign out_valid     = (sp_cnt_q != 2'd0);
   assign out_rsp       = sp_mem_q[sp_rd_q];
   assign sp_pop        = out_valid && out_ready;

   // Spill register pointer and occupancy next-state.
   always_comb begin
      sp_wr_d  = sp_wr_q ^ sp_push;
      sp_rd_d  = sp_rd_q ^ sp_pop;
      sp_cnt_d = sp_cnt_q + {1'b0, sp_push} - {1'b0, sp_pop};
   end

   // Spill register control state; it is empty after reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sp_wr_q  <= 1'b0;
         sp_rd_q  <= 1'b0;
         sp_cnt_q <= 2'd0;
      end else begin
         sp_wr_q  <= sp_wr_d;
         sp_rd_q  <= sp_rd_d;
         sp_cnt_q <= sp_cnt_d;
      end
   end

   // Spill register storage, written on an accepted, routable response.
   always_ff @(posedge clk_i) begin
      if (sp_push) begin
         sp_mem_q[sp_wr_q] <= in_rsp;
      end
   end
`else
   // Combinational routing: misrouted responses are consumed immediately.
   assign mst_p_ready_o = !rst_i && (in_bad || out_ready);
   assign out_valid     = mst_p_valid_i && !in_bad;
   assign out_rsp       = in_rsp;
`endif

endmodule
